psum_gbf_acc: RTL and testbench
===============================

// Module: psum_gbf_acc
// PURPOSE
//   Double-banked partial-sum global buffer directly downstream of su_adder_v1.
//   - Absorbs 512b su_adder write beats (psum_gbf_w_en/_addr/_num).
//   - Accumulates each beat lane-wise onto the stored partial sum (read-modify-write).
//   - Drains a completed bank to the output stream over a valid/ready handshake while
//     su_adder fills the other bank.
// PARAMETERS
//   DATA_BITWIDTH      16   lane width (signed two's complement)
//   GBF_DATA_BITWIDTH  512  word width; LANES = GBF_DATA_BITWIDTH/DATA_BITWIDTH = 32
//   DEPTH              32   words per bank
//   ADDR_BITWIDTH      5    clog2(DEPTH)
// PORTS
//   clk              in   1    clock, rising edge
//   reset            in   1    asynchronous, active-high
//   psum_gbf_w_en    in   1    write beat valid (from su_adder_v1)
//   psum_gbf_w_addr  in   5    word address within bank
//   psum_gbf_w_num   in   1    target bank (0/1)
//   in_data          in   512  su_adder out_data
//   acc_mode         in   1    1: add to stored word; 0: overwrite
//   bank_done        in   1    1-cycle pulse: bank psum_gbf_w_num fully written (su_add_finish)
//   rd_ready         in   1    downstream accepts rd_data
//   rd_valid         out  1    rd_data/rd_addr valid
//   rd_data          out  512  drained word
//   rd_addr          out  5    address of drained word
//   rd_bank          out  1    bank being drained
//   drain_done       out  1    1-cycle pulse after last beat of a bank accepted
//   bank_busy        out  2    bit b = bank b in READY or DRAIN (not writable)
//   wr_err           out  1    sticky: write or bank_done aimed at a busy bank
// BEHAVIOUR
//   Reset (async): all outputs 0; both banks FILL; all per-word valid bits 0; pipeline empty.
//   Write pipeline, 2 stages:
//     S0: register beat, read stored word and its valid bit.
//     S1: commit mem <= (acc_mode && valid) ? old + new : new; set valid bit.
//     - Invalid word (never written since reset/drain) is always overwritten.
//     - Back-to-back beats to the same bank+addr: forward the S1 result into S0;
//       no stall, no lost update.
//     - Sum per 16b lane, wrap-around modulo 2^16 (see CONFIGURATION).
//   Per-bank state FSM: FILL -> READY -> DRAIN -> FILL.
//     - FILL->READY: bank_done registered one cycle, so it follows any in-flight S1 commit.
//     - Beat or bank_done targeting a READY/DRAIN bank: dropped, wr_err set (cleared
//       only by reset).
//   Drain FSM: IDLE -> DRAIN -> IDLE.
//     - Leaves IDLE when a bank is READY. If both are READY, take the bank not drained
//       last (bank 0 after reset).
//     - rd_valid rises 1 cycle after entry; addr 0..DEPTH-1 ascending.
//     - Beat transfers when rd_valid && rd_ready.
//     - rd_data/rd_addr/rd_bank held stable while rd_valid && !rd_ready.
//     - Full throughput: 1 beat/cycle with rd_ready held high.
//     - On transfer of addr DEPTH-1: pulse drain_done, clear the bank's valid bits,
//       return the bank to FILL, return FSM to IDLE.
//     - IDLE->next DRAIN adds >= 1 bubble cycle.
//   Simultaneous events:
//     - Drain of bank A concurrent with writes to bank B: independent.
//     - bank_done for B during A's drain: B queues as READY.
//   Reset mid-operation: drain aborted, rd_valid 0 immediately; all buffered data
//   treated invalid.
// CONFIGURATION
//   PSUM_GBF_SAT_EN defined: per-lane signed saturating add; clamps to
//     +32767 / -32768 on overflow.
//   Undefined (default): wrap-around add. Overwrite path unaffected either way.
// TESTING
//   1 acc_mode=1: bank 0 written twice at addr 3 (all lanes 16'd5, then 16'd7),
//     bank_done, rd_ready=1 -> addr 3 drains all lanes 16'd12; unwritten addrs drain 0.
//   2 Back-to-back beats to bank 1 addr 0 (lanes 1,2,3 on consecutive cycles) ->
//     drained lanes 16'd6.
//   3 Lane 16'h7FFF + 16'd1: default -> 16'h8000; with PSUM_GBF_SAT_EN -> 16'h7FFF.
//   4 rd_ready toggled 1010... during a 32-word drain -> 32 beats, addr 0..31 in order,
//     data stable while stalled, one drain_done pulse.
//   5 Fill bank 0 while bank 1 drains; write to bank 1 mid-drain -> dropped, wr_err=1;
//     bank 0 drains next, bank 1 writable after its drain_done.
//   6 reset asserted at beat 10 of a drain -> rd_valid=0 same cycle; refill with
//     acc_mode=1 yields no stale accumulation.

Source files
------------

// File: rtl/psum_gbf_acc.sv
// psum_gbf_acc: double-banked partial-sum buffer with 2-stage read-modify-write accumulate
// and valid/ready bank drain. Define PSUM_GBF_SAT_EN for saturating lane adds (default wraps).
module psum_gbf_acc #(
    parameter int DATA_BITWIDTH     = 16,
    parameter int GBF_DATA_BITWIDTH = 512,
    parameter int DEPTH             = 32,
    parameter int ADDR_BITWIDTH     = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         psum_gbf_w_en,
    input  logic [ADDR_BITWIDTH-1:0]     psum_gbf_w_addr,
    input  logic                         psum_gbf_w_num,
    input  logic [GBF_DATA_BITWIDTH-1:0] in_data,
    input  logic                         acc_mode,
    input  logic                         bank_done,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [GBF_DATA_BITWIDTH-1:0] rd_data,
    output logic [ADDR_BITWIDTH-1:0]     rd_addr,
    output logic                         rd_bank,
    output logic                         drain_done,
    output logic [1:0]                   bank_busy,
    output logic                         wr_err
);
    localparam int DW    = DATA_BITWIDTH;
    localparam int GW    = GBF_DATA_BITWIDTH;
    localparam int AW    = ADDR_BITWIDTH;
    localparam int LANES = GW / DW;
    localparam logic [AW:0]   CNT_END   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH-1);
    localparam logic [DW-1:0] LANE_MAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] LANE_MIN  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {BANK_FILL = 2'd0, BANK_READY = 2'd1, BANK_DRAIN = 2'd2} bank_state_e;
    typedef enum logic {DR_IDLE = 1'b0, DR_ACTIVE = 1'b1} drain_state_e;

    genvar gi;

    // Both banks share one array, indexed {bank, addr}
    logic [GW-1:0]      mem_q [0:2*DEPTH-1];
    logic [2*DEPTH-1:0] word_valid_q, word_valid_d;

    logic [1:0] bank_is_fill;
    logic [1:0] bank_is_ready;

    // Write pipeline
    logic          w_blocked, w_accept, fwd_hit;
    logic [AW:0]   w_idx;
    logic          s1_valid_q, s1_bank_q, s1_acc_q, s1_old_valid_q;
    logic [AW-1:0] s1_addr_q;
    logic [GW-1:0] s1_new_q, s1_old_q, s1_sum, s1_result;
    logic          done_q, done_bank_q, wr_err_q;

    // Drain
    drain_state_e  dr_state_q, dr_state_d;
    logic          drain_bank_q, prefer_q, drain_done_q, rd_valid_q;
    logic [AW:0]   fetch_cnt_q;
    logic [AW:0]   rd_idx;
    logic [AW-1:0] rd_addr_q;
    logic [GW-1:0] rd_data_q;
    logic          drain_start, drain_sel, rd_fire, drain_last, load;

    assign w_blocked = !bank_is_fill[psum_gbf_w_num];
    assign w_accept  = psum_gbf_w_en && !w_blocked;
    assign w_idx     = {psum_gbf_w_num, psum_gbf_w_addr};
    // A beat following one to the same word takes the not-yet-committed S1 result
    assign fwd_hit   = s1_valid_q && (s1_bank_q == psum_gbf_w_num) && (s1_addr_q == psum_gbf_w_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q     <= 1'b0;
            s1_bank_q      <= 1'b0;
            s1_addr_q      <= '0;
            s1_new_q       <= '0;
            s1_old_q       <= '0;
            s1_old_valid_q <= 1'b0;
            s1_acc_q       <= 1'b0;
            done_q         <= 1'b0;
            done_bank_q    <= 1'b0;
            wr_err_q       <= 1'b0;
        end else begin
            s1_valid_q  <= w_accept;
            done_q      <= bank_done && !w_blocked;
            done_bank_q <= psum_gbf_w_num;
            wr_err_q    <= wr_err_q | ((psum_gbf_w_en | bank_done) & w_blocked);
            if (w_accept) begin
                s1_bank_q      <= psum_gbf_w_num;
                s1_addr_q      <= psum_gbf_w_addr;
                s1_new_q       <= in_data;
                s1_acc_q       <= acc_mode;
                s1_old_q       <= fwd_hit ? s1_result : mem_q[w_idx];
                s1_old_valid_q <= fwd_hit || word_valid_q[w_idx];
            end
        end
    end

    for (gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DW:0] wide;
        assign wide = {s1_old_q[gi*DW+DW-1], s1_old_q[gi*DW +: DW]}
                    + {s1_new_q[gi*DW+DW-1], s1_new_q[gi*DW +: DW]};
`ifdef PSUM_GBF_SAT_EN
        assign s1_sum[gi*DW +: DW] = (wide[DW] != wide[DW-1]) ? (wide[DW] ? LANE_MIN : LANE_MAX)
                                                              : wide[DW-1:0];
`else
        assign s1_sum[gi*DW +: DW] = wide[DW-1:0];
`endif
    end

    assign s1_result = (s1_acc_q && s1_old_valid_q) ? s1_sum : s1_new_q;

    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            mem_q[{s1_bank_q, s1_addr_q}] <= s1_result;
        end
    end

    always_comb begin
        word_valid_d = word_valid_q;
        if (drain_last) begin
            if (drain_bank_q) word_valid_d[DEPTH +: DEPTH] = '0;
            else              word_valid_d[0 +: DEPTH]     = '0;
        end
        if (s1_valid_q) begin
            word_valid_d[{s1_bank_q, s1_addr_q}] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) word_valid_q <= '0;
        else       word_valid_q <= word_valid_d;
    end

    for (gi = 0; gi < 2; gi++) begin : g_bank
        bank_state_e state_q, state_d;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) state_q <= BANK_FILL;
            else       state_q <= state_d;
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                BANK_FILL:  if (done_q && done_bank_q == 1'(gi))            state_d = BANK_READY;
                BANK_READY: if (drain_start && drain_sel == 1'(gi))         state_d = BANK_DRAIN;
                BANK_DRAIN: if (drain_last && drain_bank_q == 1'(gi))       state_d = BANK_FILL;
                default:                                                    state_d = BANK_FILL;
            endcase
        end

        assign bank_is_fill[gi]  = (state_q == BANK_FILL);
        assign bank_is_ready[gi] = (state_q == BANK_READY);
        assign bank_busy[gi]     = (state_q != BANK_FILL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) dr_state_q <= DR_IDLE;
        else       dr_state_q <= dr_state_d;
    end

    always_comb begin
        dr_state_d = dr_state_q;
        case (dr_state_q)
            DR_IDLE:   if (bank_is_ready != 2'b00) dr_state_d = DR_ACTIVE;
            DR_ACTIVE: if (drain_last)             dr_state_d = DR_IDLE;
            default:                               dr_state_d = DR_IDLE;
        endcase
    end

    always_comb begin
        drain_start = 1'b0;
        drain_sel   = prefer_q;
        if (dr_state_q == DR_IDLE && bank_is_ready != 2'b00) begin
            drain_start = 1'b1;
            drain_sel   = (bank_is_ready == 2'b11) ? prefer_q : bank_is_ready[1];
        end
        rd_fire    = rd_valid_q && rd_ready;
        drain_last = (dr_state_q == DR_ACTIVE) && rd_fire && (rd_addr_q == LAST_ADDR);
        // Output register refills whenever it is empty or being consumed this cycle
        load       = (dr_state_q == DR_ACTIVE) && (fetch_cnt_q != CNT_END) && (!rd_valid_q || rd_ready);
    end

    assign rd_idx = {drain_bank_q, fetch_cnt_q[AW-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_bank_q <= 1'b0;
            prefer_q     <= 1'b0;
            fetch_cnt_q  <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_addr_q    <= '0;
            drain_done_q <= 1'b0;
        end else begin
            drain_done_q <= drain_last;
            if (drain_start) begin
                drain_bank_q <= drain_sel;
                fetch_cnt_q  <= '0;
            end else if (load) begin
                fetch_cnt_q  <= fetch_cnt_q + 1'b1;
            end
            if (load) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= word_valid_q[rd_idx] ? mem_q[rd_idx] : '0;
                rd_addr_q  <= fetch_cnt_q[AW-1:0];
            end else if (rd_fire) begin
                rd_valid_q <= 1'b0;
            end
            if (drain_last) begin
                prefer_q <= ~drain_bank_q;
            end
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_addr    = rd_addr_q;
    assign rd_bank    = drain_bank_q;
    assign drain_done = drain_done_q;
    assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_psum_gbf_acc.sv
// Directed bench for psum_gbf_acc: accumulate, forwarding, lane overflow, stalled drain,
// bank interleaving and mid-drain reset.
`timescale 1ns/1ps
module tb_psum_gbf_acc;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         psum_gbf_w_en = 1'b0;
    logic [4:0]   psum_gbf_w_addr = '0;
    logic         psum_gbf_w_num = 1'b0;
    logic [511:0] in_data = '0;
    logic         acc_mode = 1'b0;
    logic         bank_done = 1'b0;
    logic         rd_ready = 1'b0;
    logic         rd_valid;
    logic [511:0] rd_data;
    logic [4:0]   rd_addr;
    logic         rd_bank;
    logic         drain_done;
    logic [1:0]   bank_busy;
    logic         wr_err;

    int checks = 0;
    int errors = 0;

    logic [511:0] cap_data [32];
    logic [4:0]   cap_addr [32];
    logic         cap_bank [32];
    int           cap_n, cap_done, cap_stable_err;

    always #5 clk = ~clk;

    psum_gbf_acc dut (
        .clk(clk), .reset(reset),
        .psum_gbf_w_en(psum_gbf_w_en), .psum_gbf_w_addr(psum_gbf_w_addr),
        .psum_gbf_w_num(psum_gbf_w_num), .in_data(in_data), .acc_mode(acc_mode),
        .bank_done(bank_done), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .drain_done(drain_done), .bank_busy(bank_busy), .wr_err(wr_err)
    );

    function automatic logic [511:0] rep(input logic [15:0] v);
        return {32{v}};
    endfunction

    task automatic write_beat(input logic bank, input logic [4:0] addr, input logic [15:0] val,
                              input logic acc, input logic done);
        psum_gbf_w_en = 1'b1; psum_gbf_w_num = bank; psum_gbf_w_addr = addr;
        in_data = rep(val); acc_mode = acc; bank_done = done;
        $display("write bank=%0d addr=%0d lane=%h acc=%0b done=%0b", bank, addr, val, acc, done);
        @(negedge clk);
        psum_gbf_w_en = 1'b0; bank_done = 1'b0; acc_mode = 1'b0;
    endtask

    task automatic pulse_done(input logic bank);
        bank_done = 1'b1; psum_gbf_w_num = bank;
        $display("bank_done bank=%0d", bank);
        @(negedge clk);
        bank_done = 1'b0;
    endtask

    // Collects one 32-beat drain; toggle=1 drives rd_ready 1,0,1,0...
    task automatic drain_capture(input bit toggle);
        logic [511:0] prev_data;
        logic [4:0]   prev_addr;
        logic         prev_bank;
        bit           prev_stall;
        int           extra;
        cap_n = 0; cap_done = 0; cap_stable_err = 0; prev_stall = 0; extra = 0;
        prev_data = '0; prev_addr = '0; prev_bank = 1'b0;
        for (int i = 0; i < 32; i++) cap_data[i] = 'x;
        for (int cyc = 0; cyc < 400 && extra < 3; cyc++) begin
            if (drain_done === 1'b1) cap_done++;
            if (prev_stall && (rd_valid !== 1'b1 || rd_data !== prev_data ||
                               rd_addr !== prev_addr || rd_bank !== prev_bank)) cap_stable_err++;
            if (cap_n < 32) rd_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            else begin rd_ready = 1'b0; extra++; end
            if (rd_valid === 1'b1 && rd_ready && cap_n < 32) begin
                cap_data[cap_n] = rd_data; cap_addr[cap_n] = rd_addr; cap_bank[cap_n] = rd_bank;
                $display("drain beat bank=%0d addr=%0d lane0=%h", rd_bank, rd_addr, rd_data[15:0]);
                cap_n++;
            end
            prev_stall = (rd_valid === 1'b1) && !rd_ready;
            prev_data = rd_data; prev_addr = rd_addr; prev_bank = rd_bank;
            @(negedge clk);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b exp 0", rd_valid); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL reset_rd_addr got %0d exp 0", rd_addr); end
        checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL reset_rd_bank got %0b exp 0", rd_bank); end
        checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL reset_drain_done got %0b exp 0", drain_done); end
        checks++; if (bank_busy !== 2'b00) begin errors++; $display("FAIL reset_bank_busy got %b exp 00", bank_busy); end
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err got %0b exp 0", wr_err); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_accumulate();
        logic [511:0] exp;
        write_beat(1'b0, 5'd3, 16'd5, 1'b1, 1'b0);
        @(negedge clk);
        write_beat(1'b0, 5'd3, 16'd7, 1'b1, 1'b0);
        pulse_done(1'b0);
        drain_capture(1'b0);
        checks++; if (cap_n != 32) begin errors++; $display("FAIL acc_beats got %0d exp 32", cap_n); end
        for (int i = 0; i < 32; i++) begin
            exp = (i == 3) ? rep(16'd12) : '0;
            checks++;
            if (cap_data[i] !== exp || cap_addr[i] !== 5'(i)) begin
                errors++; $display("FAIL acc_word%0d got addr %0d data %h exp addr %0d data %h", i, cap_addr[i], cap_data[i], i, exp);
            end
        end
        checks++; if (cap_bank[3] !== 1'b0) begin errors++; $display("FAIL acc_bank got %0b exp 0", cap_bank[3]); end
        checks++; if (cap_done != 1) begin errors++; $display("FAIL acc_drain_done got %0d exp 1", cap_done); end
    endtask

    task automatic test_back_to_back();
        write_beat(1'b1, 5'd0, 16'd1, 1'b1, 1'b0);
        write_beat(1'b1, 5'd0, 16'd2, 1'b1, 1'b0);
        write_beat(1'b1, 5'd0, 16'd3, 1'b1, 1'b1);
        drain_capture(1'b0);
        checks++; if (cap_n != 32) begin errors++; $display("FAIL b2b_beats got %0d exp 32", cap_n); end
        checks++; if (cap_data[0] !== rep(16'd6)) begin errors++; $display("FAIL b2b_data got %h exp %h", cap_data[0], rep(16'd6)); end
        checks++; if (cap_data[1] !== '0) begin errors++; $display("FAIL b2b_unwritten got %h exp 0", cap_data[1]); end
        checks++; if (cap_bank[0] !== 1'b1) begin errors++; $display("FAIL b2b_bank got %0b exp 1", cap_bank[0]); end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_pos, exp_neg;
`ifdef PSUM_GBF_SAT_EN
        exp_pos = 16'h7FFF; exp_neg = 16'h8000;
`else
        exp_pos = 16'h8000; exp_neg = 16'h7FFF;
`endif
        write_beat(1'b0, 5'd5, 16'h7FFF, 1'b1, 1'b0);
        write_beat(1'b0, 5'd5, 16'h0001, 1'b1, 1'b0);
        write_beat(1'b0, 5'd6, 16'd5, 1'b0, 1'b0);
        write_beat(1'b0, 5'd6, 16'd9, 1'b0, 1'b0);
        write_beat(1'b0, 5'd7, 16'h8000, 1'b1, 1'b0);
        write_beat(1'b0, 5'd7, 16'hFFFF, 1'b1, 1'b1);
        drain_capture(1'b0);
        checks++; if (cap_n != 32) begin errors++; $display("FAIL ovf_beats got %0d exp 32", cap_n); end
        checks++; if (cap_data[5] !== rep(exp_pos)) begin errors++; $display("FAIL ovf_pos got %h exp %h", cap_data[5], rep(exp_pos)); end
        checks++; if (cap_data[6] !== rep(16'd9)) begin errors++; $display("FAIL ovf_overwrite got %h exp %h", cap_data[6], rep(16'd9)); end
        checks++; if (cap_data[7] !== rep(exp_neg)) begin errors++; $display("FAIL ovf_neg got %h exp %h", cap_data[7], rep(exp_neg)); end
        checks++; if (cap_bank[5] !== 1'b0) begin errors++; $display("FAIL ovf_bank got %0b exp 0", cap_bank[5]); end
    endtask

    task automatic test_stall_drain();
        logic [511:0] exp;
        for (int a = 0; a < 32; a++) write_beat(1'b1, 5'(a), 16'(a*3+1), 1'b0, a == 31);
        drain_capture(1'b1);
        checks++; if (cap_n != 32) begin errors++; $display("FAIL stall_beats got %0d exp 32", cap_n); end
        for (int i = 0; i < 32; i++) begin
            exp = rep(16'(i*3+1));
            checks++;
            if (cap_addr[i] !== 5'(i) || cap_data[i] !== exp || cap_bank[i] !== 1'b1) begin
                errors++; $display("FAIL stall_word%0d got addr %0d bank %0b data %h exp addr %0d bank 1 data %h", i, cap_addr[i], cap_bank[i], cap_data[i], i, exp);
            end
        end
        checks++; if (cap_stable_err != 0) begin errors++; $display("FAIL stall_stable got %0d changes exp 0", cap_stable_err); end
        checks++; if (cap_done != 1) begin errors++; $display("FAIL stall_drain_done got %0d exp 1", cap_done); end
    endtask

    task automatic test_concurrent();
        int n;
        write_beat(1'b1, 5'd0, 16'h0011, 1'b0, 1'b0);
        pulse_done(1'b1);
        rd_ready = 1'b0;
        n = 0;
        while (rd_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (rd_valid !== 1'b1 || rd_bank !== 1'b1) begin errors++; $display("FAIL conc_start got valid %0b bank %0b exp valid 1 bank 1", rd_valid, rd_bank); end
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL conc_err_pre got %0b exp 0", wr_err); end
        write_beat(1'b0, 5'd2, 16'h0022, 1'b0, 1'b0);
        write_beat(1'b1, 5'd0, 16'h0099, 1'b0, 1'b0);
        checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL conc_err_set got %0b exp 1", wr_err); end
        checks++; if (bank_busy !== 2'b10) begin errors++; $display("FAIL conc_busy_drain got %b exp 10", bank_busy); end
        pulse_done(1'b0);
        @(negedge clk);
        checks++; if (bank_busy !== 2'b11) begin errors++; $display("FAIL conc_busy_both got %b exp 11", bank_busy); end
        drain_capture(1'b0);
        checks++; if (cap_n != 32 || cap_bank[0] !== 1'b1) begin errors++; $display("FAIL conc_b1_drain got beats %0d bank %0b exp 32 bank 1", cap_n, cap_bank[0]); end
        checks++; if (cap_data[0] !== rep(16'h0011)) begin errors++; $display("FAIL conc_b1_data got %h exp %h", cap_data[0], rep(16'h0011)); end
        drain_capture(1'b0);
        checks++; if (cap_n != 32 || cap_bank[0] !== 1'b0) begin errors++; $display("FAIL conc_b0_drain got beats %0d bank %0b exp 32 bank 0", cap_n, cap_bank[0]); end
        checks++; if (cap_data[2] !== rep(16'h0022)) begin errors++; $display("FAIL conc_b0_data got %h exp %h", cap_data[2], rep(16'h0022)); end
        checks++; if (bank_busy !== 2'b00 || wr_err !== 1'b1) begin errors++; $display("FAIL conc_after got busy %b err %0b exp busy 00 err 1", bank_busy, wr_err); end
        write_beat(1'b1, 5'd1, 16'h0033, 1'b1, 1'b1);
        drain_capture(1'b0);
        checks++; if (cap_n != 32 || cap_data[1] !== rep(16'h0033)) begin errors++; $display("FAIL conc_rewrite got beats %0d data %h exp 32 %h", cap_n, cap_data[1], rep(16'h0033)); end
        checks++; if (cap_data[0] !== '0) begin errors++; $display("FAIL conc_cleared got %h exp 0", cap_data[0]); end
    endtask

    task automatic test_reset_mid_drain();
        int n, cyc;
        write_beat(1'b0, 5'd4, 16'd3, 1'b0, 1'b1);
        rd_ready = 1'b1; n = 0; cyc = 0;
        while (n < 10 && cyc < 100) begin
            if (rd_valid === 1'b1) n++;
            @(negedge clk); cyc++;
        end
        checks++; if (rd_valid !== 1'b1 || rd_addr !== 5'd10) begin errors++; $display("FAIL rst_beat10 got valid %0b addr %0d exp valid 1 addr 10", rd_valid, rd_addr); end
        rd_ready = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", rd_valid); end
        checks++; if (bank_busy !== 2'b00 || wr_err !== 1'b0) begin errors++; $display("FAIL rst_state got busy %b err %0b exp 00 0", bank_busy, wr_err); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        write_beat(1'b0, 5'd4, 16'd2, 1'b1, 1'b1);
        drain_capture(1'b0);
        checks++; if (cap_n != 32 || cap_data[4] !== rep(16'd2)) begin errors++; $display("FAIL rst_refill got beats %0d data %h exp 32 %h", cap_n, cap_data[4], rep(16'd2)); end
        checks++; if (cap_bank[4] !== 1'b0) begin errors++; $display("FAIL rst_bank got %0b exp 0", cap_bank[4]); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_accumulate();
        test_back_to_back();
        test_overflow();
        test_stall_drain();
        test_concurrent();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
